// File: rtl/oam_dma.sv
// NES sprite DMA: halts the CPU and copies one 256-byte page into PPU OAM.
// All state advances on the falling clock edge, in step with the 6502 core.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDRESS  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDRESS = 16'h2004
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cpu_rw,
  input  logic [15:0] i_cpu_address,
  input  logic [7:0]  i_cpu_data,
  output logic        o_cpu_rdy,
  output logic        o_bus_rw,
  output logic [15:0] o_bus_address,
  output logic [7:0]  o_bus_data,
  input  logic [7:0]  i_bus_data,
  output logic        o_debug_active,
  output logic [7:0]  o_debug_offset
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] r_page;
  logic [7:0] r_offset;
  logic [7:0] r_byte;
  logic       r_parity;
  logic       trigger;

  assign trigger = !i_cpu_rw && (i_cpu_address == DMA_REG_ADDRESS);

  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      r_page   <= 8'h00;
      r_offset <= 8'h00;
      r_byte   <= 8'h00;
      r_parity <= 1'b0;
    end else begin
      state    <= state_nx;
      r_parity <= ~r_parity;
      case (state)
        IDLE: begin
          if (trigger) begin
            r_page   <= i_cpu_data;
            r_offset <= 8'h00;
          end
        end
        READ:    r_byte   <= i_bus_data;
        WRITE:   r_offset <= r_offset + 8'h01;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx      = state;
    o_cpu_rdy     = 1'b0;
    o_bus_rw      = 1'b1;
    o_bus_address = {r_page, 8'h00};
    o_bus_data    = 8'h00;
    unique case (state)
      IDLE: begin
        o_cpu_rdy     = 1'b1;
        o_bus_rw      = i_cpu_rw;
        o_bus_address = i_cpu_address;
        o_bus_data    = i_cpu_data;
        if (trigger) state_nx = HALT;
      end
      // Reads must fall on even parity; an odd halt cycle skips alignment.
      HALT:  state_nx = r_parity ? READ : ALIGN;
      ALIGN: state_nx = READ;
      READ: begin
        o_bus_address = {r_page, r_offset};
        state_nx      = WRITE;
      end
      WRITE: begin
        o_bus_rw      = 1'b0;
        o_bus_address = OAM_DATA_ADDRESS;
        o_bus_data    = r_byte;
        state_nx      = (r_offset == 8'hFF) ? IDLE : READ;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign o_debug_active = (state != IDLE);
  assign o_debug_offset = r_offset;

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: expected DMA bus cycles are queued by the
// stimulus and consumed by a monitor whenever the CPU is held off the bus.
module tb_oam_dma;

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
  } cyc_t;

  logic        clk = 1'b1;
  logic        i_reset = 1'b1;
  logic        i_cpu_rw = 1'b1;
  logic [15:0] i_cpu_address = 16'h0000;
  logic [7:0]  i_cpu_data = 8'h00;
  logic        o_cpu_rdy;
  logic        o_bus_rw;
  logic [15:0] o_bus_address;
  logic [7:0]  o_bus_data;
  logic [7:0]  i_bus_data;
  logic        o_debug_active;
  logic [7:0]  o_debug_offset;

  cyc_t exp_q[$];
  int   exp_len[$];
  int   total = 0;
  int   bad = 0;
  int   lowcnt = 0;
  bit   mon_on = 0;
  bit   par = 0;

  oam_dma dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_cpu_rw      (i_cpu_rw),
    .i_cpu_address (i_cpu_address),
    .i_cpu_data    (i_cpu_data),
    .o_cpu_rdy     (o_cpu_rdy),
    .o_bus_rw      (o_bus_rw),
    .o_bus_address (o_bus_address),
    .o_bus_data    (o_bus_data),
    .i_bus_data    (i_bus_data),
    .o_debug_active(o_debug_active),
    .o_debug_offset(o_debug_offset)
  );

  always #5 clk = ~clk;

  // memory model
  assign i_bus_data = o_bus_address[7:0] ^ 8'h5A;

  // cycle parity as defined for the engine: cleared by reset, toggles otherwise
  always @(negedge clk) par <= i_reset ? 1'b0 : ~par;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, want, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (mon_on) begin
      if (!o_cpu_rdy) begin
        lowcnt++;
        chk("active_hi", {31'b0, o_debug_active}, 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_dma", {7'b0, o_bus_rw, o_bus_address, o_bus_data},
              32'hFFFF_FFFF);
        end else begin
          cyc_t e;
          e = exp_q.pop_front();
          chk("dma_cycle", {7'b0, o_bus_rw, o_bus_address, o_bus_data},
              {7'b0, e.rw, e.addr, e.data});
        end
      end else begin
        chk("passthru", {7'b0, o_bus_rw, o_bus_address, o_bus_data},
            {7'b0, i_cpu_rw, i_cpu_address, i_cpu_data});
        chk("idle_dbg", {23'b0, o_debug_active, o_debug_offset}, 32'd0);
        if (lowcnt > 0) begin
          if (exp_len.size() == 0) chk("rdy_low_len", lowcnt, 32'hFFFF_FFFF);
          else chk("rdy_low_len", lowcnt, exp_len.pop_front());
          lowcnt = 0;
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      i_cpu_rw      = $urandom_range(0, 1);
      i_cpu_address = 16'($urandom);
      if (i_cpu_address == 16'h4014) i_cpu_address = 16'h4015;
      i_cpu_data    = 8'($urandom);
    end
  endtask

  task automatic sync_par(input bit b);
    while (par != b) idle(1);
  endtask

  task automatic trig(input logic [7:0] pg, input bit rst_mid);
    bit   al;
    int   nw;
    int   n;
    cyc_t c;
    @(posedge clk);
    // halt cycle has the opposite parity; an even halt needs one align cycle
    al = par;
    i_cpu_rw      = 1'b0;
    i_cpu_address = 16'h4014;
    i_cpu_data    = pg;
    c = '{rw: 1'b1, addr: {pg, 8'h00}, data: 8'h00};
    exp_q.push_back(c);
    if (al) exp_q.push_back(c);
    nw = rst_mid ? 100 : 256;
    for (int i = 0; i < nw; i++) begin
      c = '{rw: 1'b1, addr: {pg, 8'(i)}, data: 8'h00};
      exp_q.push_back(c);
      c = '{rw: 1'b0, addr: 16'h2004, data: 8'(i) ^ 8'h5A};
      exp_q.push_back(c);
    end
    if (rst_mid) begin
      c = '{rw: 1'b1, addr: {pg, 8'd100}, data: 8'h00};
      exp_q.push_back(c);
    end
    n = 1 + int'(al) + 2 * nw + (rst_mid ? 1 : 0);
    exp_len.push_back(n);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      i_cpu_rw      = 1'b1;
      i_cpu_address = 16'h0000;
      i_cpu_data    = 8'h00;
      if (k == 5) begin
        i_cpu_rw      = 1'b0;
        i_cpu_address = 16'h4014;
        i_cpu_data    = 8'h33;
      end
      if (rst_mid && k == n) i_reset = 1'b1;
    end
    if (rst_mid) begin
      idle(1);
      i_reset = 1'b0;
    end
  endtask

  initial begin
    @(negedge clk);
    mon_on = 1;
    idle(3);
    i_reset = 1'b0;
    idle(4);
    // reset during idle traffic
    i_reset = 1'b1;
    idle(1);
    i_reset = 1'b0;
    idle(4);
    // halt on odd parity: no align
    sync_par(1'b0);
    trig(8'h02, 1'b0);
    idle(3);
    // halt on even parity: align inserted
    sync_par(1'b1);
    trig(8'h02, 1'b0);
    // back-to-back from a new page
    idle(2);
    trig(8'h07, 1'b0);
    idle(2);
    // reading the trigger register does nothing
    @(posedge clk);
    i_cpu_rw      = 1'b1;
    i_cpu_address = 16'h4014;
    i_cpu_data    = 8'h09;
    idle(2);
    // reset and trigger together: reset wins
    @(posedge clk);
    i_reset       = 1'b1;
    i_cpu_rw      = 1'b0;
    i_cpu_address = 16'h4014;
    i_cpu_data    = 8'h09;
    idle(1);
    i_reset = 1'b0;
    idle(3);
    // page $40 source, then abandon after 100 writes
    sync_par(1'b1);
    trig(8'h40, 1'b1);
    idle(5);
    sync_par(1'b0);
    trig(8'h03, 1'b1);
    idle(5);
    chk("q_empty", exp_q.size(), 32'd0);
    chk("len_empty", exp_len.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
